// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the RV32M multiply/divide unit
package muldiv_pkg;

   localparam int MULDIV_DATA_WIDTH  = 32;
   localparam int MULDIV_CALC_CYCLES = MULDIV_DATA_WIDTH;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } muldiv_op_e;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      CALC = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } muldiv_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with register-file writeback
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int DATA_WIDTH = MULDIV_DATA_WIDTH,
   parameter int ADR_WIDTH  = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [2:0]            op_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   input  logic [ADR_WIDTH-1:0]  rd_i,
   input  logic                  flush_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic [ADR_WIDTH-1:0]  rd_o,
   output logic                  we_o
);

   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);
   localparam logic [DATA_WIDTH-1:0] MIN_INT = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   muldiv_state_e           state;
   muldiv_op_e              op_q;
   logic [DATA_WIDTH-1:0]   a_q, b_q, hi, lo;
   logic                    a_neg, b_neg;
   logic [ADR_WIDTH-1:0]    rd_q;
   logic [CNT_W-1:0]        cnt;

   logic                    sign_a, sign_b, is_div;
   logic [DATA_WIDTH-1:0]   mag_a, mag_b;
   logic                    special;
   logic [DATA_WIDTH-1:0]   special_val;
   logic [DATA_WIDTH:0]     mul_sum, div_sh, div_diff;
   logic [2*DATA_WIDTH-1:0] prod_fix;
   logic [DATA_WIDTH-1:0]   quo_fix, rem_fix, fix_val;

   always_comb begin
      sign_a = op_q inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
      sign_b = op_q inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
      is_div = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
      mag_a  = (sign_a && a_q[DATA_WIDTH-1]) ? -a_q : a_q;
      mag_b  = (sign_b && b_q[DATA_WIDTH-1]) ? -b_q : b_q;
   end

   // Divide-by-zero and signed overflow are resolved from the raw request in IDLE.
   always_comb begin
      special     = 1'b0;
      special_val = '0;
      if (op_i[2]) begin
         if (b_i == '0) begin
            special     = 1'b1;
            special_val = op_i[1] ? a_i : '1;
         end else if (!op_i[0] && a_i == MIN_INT && b_i == '1) begin
            special     = 1'b1;
            special_val = op_i[1] ? '0 : a_i;
         end
      end
   end

   // hi:lo is the product register for multiply and the remainder:quotient pair for divide.
   always_comb begin
      mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, a_q} : '0);
      div_sh   = {hi, lo[DATA_WIDTH-1]};
      div_diff = div_sh - {1'b0, b_q};
   end

   always_comb begin
      prod_fix = (a_neg ^ b_neg) ? -{hi, lo} : {hi, lo};
      quo_fix  = (a_neg ^ b_neg) ? -lo : lo;
      rem_fix  = a_neg ? -hi : hi;
      case (op_q)
         OP_MUL:                       fix_val = prod_fix[DATA_WIDTH-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
         OP_DIV, OP_DIVU:              fix_val = quo_fix;
         default:                      fix_val = rem_fix;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         op_q     <= OP_MUL;
         a_q      <= '0;
         b_q      <= '0;
         hi       <= '0;
         lo       <= '0;
         a_neg    <= 1'b0;
         b_neg    <= 1'b0;
         rd_q     <= '0;
         cnt      <= '0;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
         we_o     <= 1'b0;
         result_o <= '0;
         rd_o     <= '0;
      end else begin
         done_o <= 1'b0;
         we_o   <= 1'b0;
         if (flush_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            cnt    <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start_i) begin
                     op_q   <= muldiv_op_e'(op_i);
                     a_q    <= a_i;
                     b_q    <= b_i;
                     rd_q   <= rd_i;
                     busy_o <= 1'b1;
                     if (special) begin
                        result_o <= special_val;
                        rd_o     <= rd_i;
                        done_o   <= 1'b1;
                        we_o     <= (rd_i != '0);
                        state    <= DONE;
                     end else begin
                        state <= PREP;
                     end
                  end
               end
               PREP: begin
                  a_neg <= sign_a && a_q[DATA_WIDTH-1];
                  b_neg <= sign_b && b_q[DATA_WIDTH-1];
                  a_q   <= mag_a;
                  b_q   <= mag_b;
                  hi    <= '0;
                  lo    <= is_div ? mag_a : mag_b;
                  cnt   <= '0;
                  state <= CALC;
               end
               CALC: begin
                  if (is_div) begin
                     if (!div_diff[DATA_WIDTH]) begin
                        hi <= div_diff[DATA_WIDTH-1:0];
                        lo <= {lo[DATA_WIDTH-2:0], 1'b1};
                     end else begin
                        hi <= div_sh[DATA_WIDTH-1:0];
                        lo <= {lo[DATA_WIDTH-2:0], 1'b0};
                     end
                  end else begin
                     hi <= mul_sum[DATA_WIDTH:1];
                     lo <= {mul_sum[0], lo[DATA_WIDTH-1:1]};
                  end
                  if (cnt == LAST_ITER) begin
                     cnt   <= '0;
                     state <= FIX;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               FIX: begin
                  result_o <= fix_val;
                  rd_o     <= rd_q;
                  done_o   <= 1'b1;
                  we_o     <= (rd_q != '0);
                  state    <= DONE;
               end
               DONE: begin
                  busy_o <= 1'b0;
                  state  <= IDLE;
               end
               default: begin
                  busy_o <= 1'b0;
                  state  <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic [2:0]  op_i = 3'd0;
   logic [31:0] a_i = 32'd0;
   logic [31:0] b_i = 32'd0;
   logic [4:0]  rd_i = 5'd0;
   logic        flush_i = 1'b0;
   logic        busy_o, done_o, we_o;
   logic [31:0] result_o;
   logic [4:0]  rd_o;

   int total = 0;
   int bad = 0;

   muldiv_unit #(.DATA_WIDTH(32), .ADR_WIDTH(5)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
      .a_i(a_i), .b_i(b_i), .rd_i(rd_i), .flush_i(flush_i),
      .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
      .rd_o(rd_o), .we_o(we_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      case (op)
         3'd0: begin p = 64'(ua * ub); return p[31:0]; end
         3'd1: begin p = 64'(sa * sb); return p[63:32]; end
         3'd2: begin p = 64'(sa * ub); return p[63:32]; end
         3'd3: begin p = 64'(ua * ub); return p[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return 32'(sa / sb);
         end
         3'd5: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(sa % sb);
         end
         default: begin
            if (b == 32'd0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op >= 3'd4 && b == 32'd0) return 1;
      if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 35;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      op_i = op; a_i = a; b_i = b; rd_i = rd; start_i = 1'b1;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      op_i = 3'($urandom); a_i = $urandom; b_i = $urandom; rd_i = 5'($urandom);
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         @(negedge clk_i);
         lat++;
      end while (!done_o && lat < 100);
   endtask

   task automatic run_check(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
      int lat;
      @(negedge clk_i);
      issue(op, a, b, rd);
      wait_done(lat);
      chk({tag, " latency"}, 32'(lat), 32'(exp_latency(op, a, b)));
      chk({tag, " result"}, result_o, exp);
      chk({tag, " rd"}, 32'(rd_o), 32'(rd));
      chk({tag, " we"}, 32'(we_o), 32'(rd != 5'd0));
      @(negedge clk_i);
      chk({tag, " busy after"}, 32'(busy_o), 32'd0);
      chk({tag, " done pulse"}, 32'(done_o), 32'd0);
   endtask

   initial begin
      int lat;
      logic saw_done;
      logic [31:0] prev_res;
      logic [4:0] prev_rd;
      logic [2:0] rop;
      logic [31:0] ra, rb;
      logic [4:0] rrd;

      @(negedge clk_i);
      chk("reset busy", 32'(busy_o), 32'd0);
      chk("reset done", 32'(done_o), 32'd0);
      chk("reset we", 32'(we_o), 32'd0);
      chk("reset result", result_o, 32'd0);
      chk("reset rd", 32'(rd_o), 32'd0);
      rst_i = 1'b0;

      run_check("mul 7x6",     3'd0, 32'd7,          32'd6,          5'd5,  32'd42);
      run_check("mulh min",    3'd1, 32'h8000_0000,  32'h8000_0000,  5'd1,  32'h4000_0000);
      run_check("mulhsu ones", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFF);
      run_check("mulhu ones",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd3,  32'hFFFF_FFFE);
      run_check("div -7/2",    3'd4, 32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFD);
      run_check("rem -7/2",    3'd6, 32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF);
      run_check("divu 100/7",  3'd5, 32'd100,        32'd7,          5'd7,  32'd14);
      run_check("remu 100/7",  3'd7, 32'd100,        32'd7,          5'd8,  32'd2);
      run_check("divu 5/0",    3'd5, 32'd5,          32'd0,          5'd9,  32'hFFFF_FFFF);
      run_check("rem 5/0",     3'd6, 32'd5,          32'd0,          5'd10, 32'd5);
      run_check("div ovf",     3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'h8000_0000);
      run_check("rem ovf",     3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'd0);
      run_check("mul rd0",     3'd0, 32'd3,          32'd4,          5'd0,  32'd12);

      // Flush at cycle 10 of a divide, with an ignored start at cycle 5.
      @(negedge clk_i);
      prev_res = result_o;
      prev_rd = rd_o;
      issue(3'd5, 32'd1000, 32'd3, 5'd7);
      saw_done = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk_i);
         if (done_o) saw_done = 1'b1;
         start_i = (c == 5);
         if (c == 5) begin op_i = 3'd0; a_i = 32'd3; b_i = 32'd3; rd_i = 5'd9; end
         flush_i = (c == 10);
      end
      @(negedge clk_i);
      flush_i = 1'b0;
      if (done_o) saw_done = 1'b1;
      chk("flush busy", 32'(busy_o), 32'd0);
      chk("flush no done", 32'(saw_done), 32'd0);
      chk("flush result kept", result_o, prev_res);
      chk("flush rd kept", 32'(rd_o), 32'(prev_rd));
      issue(3'd6, 32'hFFFF_FF9C, 32'd7, 5'd12);
      wait_done(lat);
      chk("post flush latency", 32'(lat), 32'd35);
      chk("post flush result", result_o, model(3'd6, 32'hFFFF_FF9C, 32'd7));
      chk("post flush rd", 32'(rd_o), 32'd12);

      // Flush and start together in IDLE: nothing accepted.
      @(negedge clk_i);
      @(negedge clk_i);
      op_i = 3'd0; a_i = 32'd5; b_i = 32'd5; rd_i = 5'd3;
      start_i = 1'b1;
      flush_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      flush_i = 1'b0;
      chk("flush+start busy", 32'(busy_o), 32'd0);
      @(negedge clk_i);
      chk("flush+start busy2", 32'(busy_o), 32'd0);
      chk("flush+start done", 32'(done_o), 32'd0);

      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 15));
            2: rb = 32'hFFFF_FFFF;
            3: ra = 32'h8000_0000;
            default: ;
         endcase
         rrd = 5'($urandom);
         run_check($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, rrd, model(rop, ra, rb));
      end

      // Asynchronous reset in the middle of CALC.
      @(negedge clk_i);
      issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd21);
      repeat (8) @(negedge clk_i);
      chk("pre reset busy", 32'(busy_o), 32'd1);
      #2;
      rst_i = 1'b1;
      #1;
      chk("async reset busy", 32'(busy_o), 32'd0);
      chk("async reset done", 32'(done_o), 32'd0);
      chk("async reset we", 32'(we_o), 32'd0);
      chk("async reset result", result_o, 32'd0);
      chk("async reset rd", 32'(rd_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("after reset done", 32'(done_o), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
